// File: rtl/audio_pkg.sv
// ============================================================================
// Module : audio_pkg -- shared types for the audio output scheduler
// Rev    : 1.0
// ============================================================================
`default_nettype none

package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } sched_state_t;
endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================================
// Module : sample_fifo -- synchronous sample FIFO, async active-low reset
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sample_fifo
  import audio_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = sample_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  T                       i_data,
  input  logic                   i_pop,
  output T                       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_count == LW'(DEPTH));
  assign o_empty = (r_count == '0);
  // A push into a full FIFO is only taken when a pop frees the slot this cycle.
  assign w_rd    = i_pop & ~o_empty;
  assign w_wr    = i_push & (~o_full | w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_level = r_count;
endmodule

`default_nettype wire

// File: rtl/audio_out_scheduler.sv
// ============================================================================
// Module : audio_out_scheduler -- one DAC sample per period from a 4-deep FIFO
// Option : AUDIO_SCHED_UNDERRUN_HOLD_EN repeats the last sample on underrun
// Rev    : 1.0
// ============================================================================
`default_nettype none

module audio_out_scheduler
  import audio_pkg::*;
#(
  parameter int clock_max   = 25_000_000,
  parameter int sample_rate = 48_000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk_25mhz,
  input  logic             reset,
  input  logic             raw_valid,
  input  sample_t          raw_audio,
  input  logic             fx_valid,
  input  sample_t          fx_audio,
  input  logic             bypass_req,
  input  logic             dac_busy,
  output logic             dac_start,
  output sample_t          dac_data,
  output logic             path_sel,
  output logic [2:0]       fifo_level,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int SAMPLE_DIV = clock_max / sample_rate;
  localparam int DIV_W      = $clog2(SAMPLE_DIV);
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] c_DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [LVL_W-1:0] c_PRIME_LVL = LVL_W'(2);

  sched_state_t     r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div;
  logic             r_path;
  logic             r_start;
  sample_t          r_data;
  logic [CNT_W-1:0] r_und;
  logic [CNT_W-1:0] r_drop;

  logic             w_tick;
  logic             w_push;
  sample_t          w_push_data;
  logic             w_pop;
  logic             w_issue;
  logic             w_count_under;
  logic             w_drop;
  sample_t          w_head;
  sample_t          w_fill;
  logic             w_full;
  logic             w_empty;
  logic [LVL_W-1:0] w_level;

  assign w_tick      = (r_div == c_DIV_LAST);
  assign w_push      = r_path ? raw_valid : fx_valid;
  assign w_push_data = r_path ? raw_audio : fx_audio;
  assign w_drop      = w_push & w_full & ~w_pop;

`ifdef AUDIO_SCHED_UNDERRUN_HOLD_EN
  assign w_fill = r_data;
`else
  assign w_fill = '0;
`endif

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (sample_t)
  ) u_fifo (
    .clk     (clk_25mhz),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_issue       = 1'b0;
    w_count_under = 1'b0;
    case (r_state)
      PRIME: begin
        if (w_level >= c_PRIME_LVL) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_tick) begin
          // A busy DAC costs this period's slot entirely: nothing is consumed.
          if (dac_busy) begin
            w_count_under = 1'b1;
          end else if (!w_empty) begin
            w_pop   = 1'b1;
            w_issue = 1'b1;
          end else begin
            w_issue       = 1'b1;
            w_count_under = 1'b1;
          end
        end
      end
      default: w_state_nxt = PRIME;
    endcase
  end

  always_ff @(posedge clk_25mhz or negedge reset) begin
    if (!reset) begin
      r_state <= PRIME;
      r_div   <= '0;
      r_path  <= 1'b1;
      r_start <= 1'b0;
      r_data  <= '0;
      r_und   <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) r_path <= bypass_req;
      r_start <= w_issue;
      if (w_issue) r_data <= w_pop ? w_head : w_fill;
      if (w_count_under && (r_und != '1)) r_und <= r_und + 1'b1;
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
    end
  end

  assign dac_start    = r_start;
  assign dac_data     = r_data;
  assign path_sel     = r_path;
  assign fifo_level   = 3'(w_level);
  assign underrun_cnt = r_und;
  assign drop_cnt     = r_drop;
endmodule

`default_nettype wire

// File: tb/tb_audio_out_scheduler.sv
// ============================================================================
// Module : tb_audio_out_scheduler -- scoreboard bench for audio_out_scheduler
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_audio_out_scheduler;
  import audio_pkg::*;

  localparam int DIV        = 25_000_000 / 48_000;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       raw_valid;
  sample_t    raw_audio;
  logic       fx_valid;
  sample_t    fx_audio;
  logic       bypass_req;
  logic       dac_busy;
  logic       dac_start;
  sample_t    dac_data;
  logic       path_sel;
  logic [2:0] fifo_level;
  logic [7:0] underrun_cnt;
  logic [7:0] drop_cnt;

  audio_out_scheduler dut (
    .clk_25mhz    (clk),
    .reset        (reset),
    .raw_valid    (raw_valid),
    .raw_audio    (raw_audio),
    .fx_valid     (fx_valid),
    .fx_audio     (fx_audio),
    .bypass_req   (bypass_req),
    .dac_busy     (dac_busy),
    .dac_start    (dac_start),
    .dac_data     (dac_data),
    .path_sel     (path_sel),
    .fifo_level   (fifo_level),
    .underrun_cnt (underrun_cnt),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  int      checks   = 0;
  int      failures = 0;

  // Reference model state
  int      tb_div;
  sample_t q[$];
  logic    m_run, m_path, m_pending, m_run_t, m_busy_t, m_byp_t;
  int      m_und, m_drop;
  sample_t m_last;

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) tb_div <= 0;
    else        tb_div <= (tb_div == DIV - 1) ? 0 : tb_div + 1;
  end

  // Per-cycle monitor: resolves the previous tick, then compares every output.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      m_run = 1'b0; m_path = 1'b1; m_pending = 1'b0;
      m_und = 0; m_drop = 0; m_last = '0;
    end else begin
      if (m_pending && tb_div == 0) begin
        m_pending = 1'b0;
        m_path    = m_byp_t;
        chk("dac_start_tick", {31'd0, dac_start}, {31'd0, m_run_t && !m_busy_t});
        if (m_run_t) begin
          if (m_busy_t) m_und = sat(m_und);
          else if (q.size() != 0) m_last = q.pop_front();
          else begin
`ifndef AUDIO_SCHED_UNDERRUN_HOLD_EN
            m_last = '0;
`endif
            m_und = sat(m_und);
          end
        end
      end else begin
        chk("dac_start_idle", {31'd0, dac_start}, 32'd0);
      end
      chk("dac_data", {16'd0, dac_data}, {16'd0, m_last});
      chk("path_sel", {31'd0, path_sel}, {31'd0, m_path});
      chk("fifo_level", {29'd0, fifo_level}, q.size());
      chk("underrun_cnt", {24'd0, underrun_cnt}, m_und);
      chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
      if (tb_div == DIV - 1) begin
        m_pending = 1'b1; m_run_t = m_run; m_busy_t = dac_busy; m_byp_t = bypass_req;
      end
      if (q.size() >= 2) m_run = 1'b1;
    end
  end

  // Pushes avoid the tick cycle and its neighbours so model and DUT agree on ordering.
  task automatic push(input logic rv, input sample_t rd, input logic fv, input sample_t fd);
    logic sel;
    int   guard;
    guard = 0;
    while ((tb_div >= DIV - 2 || tb_div == 0) && guard < 10) begin
      @(posedge clk); #1; guard++;
    end
    raw_valid = rv; raw_audio = rd; fx_valid = fv; fx_audio = fd;
    sel = m_path;
    @(posedge clk); #1;
    raw_valid = 1'b0; fx_valid = 1'b0;
    if (sel ? rv : fv) begin
      if (q.size() < FIFO_DEPTH) q.push_back(sel ? rd : fd);
      else m_drop = sat(m_drop);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int b;
      b = 0;
      do begin @(posedge clk); #1; b++; end while (tb_div != 1 && b < 2 * DIV);
      if (b >= 2 * DIV) begin
        failures++;
        $display("FAIL tick_wait observed=timeout expected=tick");
      end
    end
  endtask

  initial begin
    #900_000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int b;
    reset = 1'b0; raw_valid = 1'b0; raw_audio = '0; fx_valid = 1'b0; fx_audio = '0;
    bypass_req = 1'b1; dac_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dac_start", {31'd0, dac_start}, 32'd0);
    chk("rst_dac_data", {16'd0, dac_data}, 32'd0);
    chk("rst_path_sel", {31'd0, path_sel}, 32'd1);
    chk("rst_level", {29'd0, fifo_level}, 32'd0);
    chk("rst_underrun", {24'd0, underrun_cnt}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Prime with three raw samples; fx strobes must be ignored.
    push(1'b1, 16'h1111, 1'b1, 16'h9991);
    push(1'b1, 16'h2222, 1'b1, 16'h9992);
    push(1'b1, 16'h3333, 1'b0, 16'h0000);
    chk("prime_level", {29'd0, fifo_level}, 32'd3);
    b = 0;
    do begin @(negedge clk); b++; end while (!dac_start && b < 2 * DIV);
    chk("first_issue_seen", {31'd0, dac_start}, 32'd1);
    chk("first_issue_phase", tb_div, 32'd0);
    chk("first_issue_data", {16'd0, dac_data}, 32'h1111);

    // Remaining two issue, then an empty FIFO underruns.
    wait_ticks(4);
`ifdef AUDIO_SCHED_UNDERRUN_HOLD_EN
    chk("underrun_data", {16'd0, dac_data}, 32'h3333);
`else
    chk("underrun_data", {16'd0, dac_data}, 32'h0000);
`endif
    chk("underrun_cnt_1", {24'd0, underrun_cnt}, 32'd1);

    // Overfill within one period.
    for (int i = 0; i < 6; i++) push(1'b1, sample_t'(16'h4000 + i), 1'b0, '0);
    chk("full_level", {29'd0, fifo_level}, 32'd4);
    chk("drop_cnt_2", {24'd0, drop_cnt}, 32'd2);

    // Busy DAC across a tick slips, then normal pop resumes.
    dac_busy = 1'b1;
    wait_ticks(1);
    dac_busy = 1'b0;
    chk("slip_level", {29'd0, fifo_level}, 32'd4);
    chk("slip_underrun", {24'd0, underrun_cnt}, 32'd2);
    wait_ticks(1);
    chk("post_slip_data", {16'd0, dac_data}, 32'h4000);
    chk("post_slip_level", {29'd0, fifo_level}, 32'd3);
    wait_ticks(3);
    chk("drained_level", {29'd0, fifo_level}, 32'd0);

    // Path switching takes effect only on a tick.
    bypass_req = 1'b0;
    push(1'b1, 16'hA001, 1'b1, 16'hB001);
    push(1'b1, 16'hA002, 1'b1, 16'hB002);
    chk("path_hold_mid", {31'd0, path_sel}, 32'd1);
    wait_ticks(1);
    chk("path_after_tick", {31'd0, path_sel}, 32'd0);
    chk("path_issue_raw", {16'd0, dac_data}, 32'hA001);
    push(1'b1, 16'hA003, 1'b1, 16'hB003);
    push(1'b1, 16'hA004, 1'b1, 16'hB004);
    bypass_req = 1'b1;
    push(1'b1, 16'hA005, 1'b1, 16'hB005);
    chk("path_mix_level", {29'd0, fifo_level}, 32'd4);
    wait_ticks(4);
    chk("path_fx_last", {16'd0, dac_data}, 32'hB005);
    chk("path_back_raw", {31'd0, path_sel}, 32'd1);

    // Drop counter saturation.
    for (int i = 0; i < 264; i++) push(1'b1, sample_t'(i), 1'b0, '0);
    chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
    chk("sat_level", {29'd0, fifo_level}, 32'd4);

    // Reset during a tick cycle with a full FIFO.
    b = 0;
    while (tb_div != DIV - 1 && b < 2 * DIV) begin @(posedge clk); #1; b++; end
    chk("reset_at_tick", tb_div, DIV - 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_start", {31'd0, dac_start}, 32'd0);
    chk("mid_rst_data", {16'd0, dac_data}, 32'd0);
    chk("mid_rst_level", {29'd0, fifo_level}, 32'd0);
    chk("mid_rst_path", {31'd0, path_sel}, 32'd1);
    chk("mid_rst_underrun", {24'd0, underrun_cnt}, 32'd0);
    chk("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_no_start", {31'd0, dac_start}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    wait_ticks(2);
    chk("post_rst_level", {29'd0, fifo_level}, 32'd0);
    chk("post_rst_underrun", {24'd0, underrun_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
